// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset defaults,
// fetch FSM states and instruction field positions used by control.
package mips_pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
// Ports: clk, rst_n, load_i, flush_i, {instr,pc,pc_plus4}_i -> *_o, valid_o.
module if_id_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem req/ack, 1-entry stall buffer,
// redirect flush. Ports: imem_* handshake, stall_i, redirect_*, IF/ID outputs.
module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic [5:0]  instr_op_o,
    output logic [5:0]  instr_funct_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;

    logic        complete;
    logic        ifid_load;
    logic        ifid_flush;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] fetch_pc_p4;

    // Gated by rst_n so the request drops the moment reset asserts.
    assign imem_req_o  = rst_n && (state_q == FETCH || state_q == DROP);
    assign imem_addr_o = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign complete    = imem_req_o && imem_ack_i;
    assign fetch_pc_p4 = fetch_pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_instr  = buf_instr_q;
        ifid_pc     = buf_pc_q;

        if (redirect_i) begin
            ifid_flush  = 1'b1;
            buf_instr_d = NOP_INSTR;
            buf_pc_d    = 32'd0;
            fetch_pc_d  = redirect_pc_i & ~32'h3;
            // A live request cannot be withdrawn: keep its address
            // on the bus and swallow the ack in DROP.
            if (state_q == FETCH && !complete) begin
                state_d     = DROP;
                drop_addr_d = fetch_pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (complete) begin
                        fetch_pc_d = fetch_pc_p4;
                        if (stall_i) begin
                            buf_instr_d = imem_rdata_i;
                            buf_pc_d    = fetch_pc_q;
                            state_d     = HOLD;
                        end else begin
                            ifid_load  = 1'b1;
                            ifid_instr = imem_rdata_i;
                            ifid_pc    = fetch_pc_q;
                        end
                    end else if (!stall_i) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                        state_d   = FETCH;
                    end
                end
                DROP: begin
                    if (complete) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC & ~32'h3;
            drop_addr_q <= 32'd0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .instr_i    (ifid_instr),
        .pc_i       (ifid_pc),
        .pc_plus4_i (ifid_pc + 32'd4),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .valid_o    (instr_valid_o)
    );

    assign instr_op_o    = instr_o[31:OP_LSB];
    assign instr_funct_o = instr_o[FUNCT_MSB:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: handshake, stall buffer,
// redirect/drop, PC wrap and asynchronous reset mid-transaction.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic [5:0]  instr_op_o;
    logic [5:0]  instr_funct_o;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_valid_o (instr_valid_o),
        .instr_op_o    (instr_op_o),
        .instr_funct_o (instr_funct_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic ack, logic [31:0] rdata, logic stall,
        logic redir, logic [31:0] rpc,
        logic e_req, logic [31:0] e_addr,
        logic e_valid, logic [31:0] e_instr, logic [31:0] e_pc
    );
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stall;
        v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ifid(int n, logic e_valid, logic [31:0] e_instr,
                              logic [31:0] e_pc);
        logic [31:0] ei;
        logic [31:0] e4;
        ei = e_valid ? e_instr : 32'h0;
        e4 = e_pc + 32'd4;
        chk($sformatf("v%0d.valid", n), {31'd0, instr_valid_o}, {31'd0, e_valid});
        chk($sformatf("v%0d.instr", n), instr_o, ei);
        chk($sformatf("v%0d.op", n), {26'd0, instr_op_o}, {26'd0, ei[31:26]});
        chk($sformatf("v%0d.funct", n), {26'd0, instr_funct_o}, {26'd0, ei[5:0]});
        if (e_valid) begin
            chk($sformatf("v%0d.pc", n), pc_o, e_pc);
            chk($sformatf("v%0d.pc4", n), pc_plus4_o, e4);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step(int n, vec_t v);
        imem_ack_i    = v.ack;
        imem_rdata_i  = v.rdata;
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        #1;
        chk($sformatf("v%0d.req", n), {31'd0, imem_req_o}, {31'd0, v.e_req});
        if (v.e_req) chk($sformatf("v%0d.addr", n), imem_addr_o, v.e_addr);
        @(posedge clk);
        #1;
        check_ifid(n, v.e_valid, v.e_instr, v.e_pc);
        @(negedge clk);
    endtask

    localparam logic [31:0] A0  = 32'h8D09_0024;
    localparam logic [31:0] A1  = 32'h2108_0011;
    localparam logic [31:0] A2  = 32'h0123_4025;
    localparam logic [31:0] A3  = 32'hAC8A_0003;
    localparam logic [31:0] A4  = 32'h1000_FFEA;
    localparam logic [31:0] A5  = 32'h3C01_1013;
    localparam logic [31:0] A6  = 32'h0C10_0040;
    localparam logic [31:0] A7  = 32'h08F0_0008;
    localparam logic [31:0] A8  = 32'h2442_002A;
    localparam logic [31:0] A9  = 32'h0042_1821;
    localparam logic [31:0] A10 = 32'h1440_0019;
    localparam logic [31:0] A11 = 32'h0000_000C;
    localparam logic [31:0] A12 = 32'h8FBF_0038;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        rst_n = 1'b0;
        imem_ack_i = 1'b0;
        imem_rdata_i = 32'h0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;

        // zero-wait streaming
        vecs.push_back(mk(1, A0, 0, 0, 0, 1, 32'h0040_0000, 1, A0, 32'h0040_0000));
        vecs.push_back(mk(1, A1, 0, 0, 0, 1, 32'h0040_0004, 1, A1, 32'h0040_0004));
        vecs.push_back(mk(1, A2, 0, 0, 0, 1, 32'h0040_0008, 1, A2, 32'h0040_0008));
        // ack delayed three cycles
        vecs.push_back(mk(0, JUNK, 0, 0, 0, 1, 32'h0040_000C, 0, 0, 0));
        vecs.push_back(mk(0, JUNK, 0, 0, 0, 1, 32'h0040_000C, 0, 0, 0));
        vecs.push_back(mk(0, JUNK, 0, 0, 0, 1, 32'h0040_000C, 0, 0, 0));
        vecs.push_back(mk(1, A3, 0, 0, 0, 1, 32'h0040_000C, 1, A3, 32'h0040_000C));
        // stall while ack arrives, held two cycles
        vecs.push_back(mk(1, A4, 1, 0, 0, 1, 32'h0040_0010, 1, A3, 32'h0040_000C));
        vecs.push_back(mk(0, JUNK, 1, 0, 0, 0, 0, 1, A3, 32'h0040_000C));
        vecs.push_back(mk(0, JUNK, 0, 0, 0, 0, 0, 1, A4, 32'h0040_0010));
        vecs.push_back(mk(1, A5, 0, 0, 0, 1, 32'h0040_0014, 1, A5, 32'h0040_0014));
        // redirect while request pending, ack two cycles later
        vecs.push_back(mk(0, JUNK, 0, 0, 0, 1, 32'h0040_0018, 0, 0, 0));
        vecs.push_back(mk(0, JUNK, 0, 1, 32'h0040_0101, 1, 32'h0040_0018, 0, 0, 0));
        vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 32'h0040_0018, 0, 0, 0));
        vecs.push_back(mk(1, JUNK, 0, 0, 0, 1, 32'h0040_0018, 0, 0, 0));
        vecs.push_back(mk(1, A6, 0, 0, 0, 1, 32'h0040_0100, 1, A6, 32'h0040_0100));
        // redirect + stall + ack together
        vecs.push_back(mk(1, JUNK, 1, 1, 32'h0040_0200, 1, 32'h0040_0104, 0, 0, 0));
        vecs.push_back(mk(1, A7, 0, 0, 0, 1, 32'h0040_0200, 1, A7, 32'h0040_0200));
        // PC wrap
        vecs.push_back(mk(1, JUNK, 0, 1, 32'hFFFF_FFFC, 1, 32'h0040_0204, 0, 0, 0));
        vecs.push_back(mk(1, A8, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, A8, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, A9, 0, 0, 0, 1, 32'h0000_0000, 1, A9, 32'h0000_0000));
        // redirect while holding a buffered word
        vecs.push_back(mk(1, A10, 1, 0, 0, 1, 32'h0000_0004, 1, A9, 32'h0000_0000));
        vecs.push_back(mk(0, JUNK, 1, 1, 32'h0040_0300, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, A11, 0, 0, 0, 1, 32'h0040_0300, 1, A11, 32'h0040_0300));

        @(negedge clk);
        @(negedge clk);
        chk("rst.req", {31'd0, imem_req_o}, 32'd0);
        check_ifid(-1, 1'b0, 32'h0, 32'h0);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.pc4", pc_plus4_o, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) step(i, vecs[i]);

        // asynchronous reset while a request waits for its ack
        imem_ack_i = 1'b0;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        #1;
        chk("mid.req_before", {31'd0, imem_req_o}, 32'd1);
        chk("mid.addr_before", imem_addr_o, 32'h0040_0304);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.req", {31'd0, imem_req_o}, 32'd0);
        chk("mid.valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mid.instr", instr_o, 32'h0);
        chk("mid.pc", pc_o, 32'h0);
        chk("mid.pc4", pc_plus4_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(100, mk(1, A12, 0, 0, 0, 1, 32'h0040_0000, 1, A12, 32'h0040_0000));
        step(101, mk(0, JUNK, 0, 0, 0, 1, 32'h0040_0004, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
